mem_port_arbiter: RTL

Shares the single byte-serial RAM transaction engine between the instruction-fetch unit (IF) and the load/store unit (LS). Arbitrates level-held requests with LS priority plus an IF anti-starvation counter, issues one transaction at a time to the engine, and routes the completion and read data back to the winning requester. Also discards in-flight IF results on a pipeline flush.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared byte-serial RAM engine between instruction fetch (IF) and load/store (LS).
// LS has priority; an anti-starvation counter forces an IF grant after STARVE_MAX consecutive LS wins.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [2:0]        ls_len,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic              eng_valid,
  input  logic              eng_ready,
  output logic              eng_wr,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [2:0]        eng_len,
  output logic [31:0]       eng_wdata,
  input  logic              eng_done,
  input  logic [31:0]       eng_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state;
  logic              r_own_if;
  logic              r_discard;
  logic [3:0]        r_starve;
  logic              r_if_done;
  logic [31:0]       r_if_inst;
  logic              r_ls_done;
  logic [31:0]       r_ls_rdata;
  logic              r_eng_valid;
  logic              r_eng_wr;
  logic [ADDR_W-1:0] r_eng_addr;
  logic [2:0]        r_eng_len;
  logic [31:0]       r_eng_wdata;

  logic              w_pick_ls;
  logic              w_starve_full;
  logic [2:0]        w_ls_len;
  logic              w_kill;
  logic [31:0]       w_rdata_ext;

  assign w_starve_full = (r_starve == 4'(STARVE_MAX));
  assign w_pick_ls     = ls_req && !(if_req && w_starve_full);
  assign w_ls_len      = (ls_len == 3'd1) ? 3'd1 : (ls_len == 3'd2) ? 3'd2 : 3'd4;
  // A flush arriving together with eng_done still discards the fetch.
  assign w_kill        = r_discard || flush;

  always_comb begin
    w_rdata_ext = eng_rdata;
    case (r_eng_len)
      3'd1:    w_rdata_ext = {24'd0, eng_rdata[7:0]};
      3'd2:    w_rdata_ext = {16'd0, eng_rdata[15:0]};
      default: w_rdata_ext = eng_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_own_if    <= 1'b0;
      r_discard   <= 1'b0;
      r_starve    <= '0;
      r_if_done   <= 1'b0;
      r_if_inst   <= '0;
      r_ls_done   <= 1'b0;
      r_ls_rdata  <= '0;
      r_eng_valid <= 1'b0;
      r_eng_wr    <= 1'b0;
      r_eng_addr  <= '0;
      r_eng_len   <= '0;
      r_eng_wdata <= '0;
    end else if (rdy) begin
      case (r_state)
        IDLE: begin
          if (w_pick_ls) begin
            r_own_if    <= 1'b0;
            r_eng_wr    <= ls_wr;
            r_eng_addr  <= ls_addr;
            r_eng_len   <= w_ls_len;
            r_eng_wdata <= ls_wdata;
            r_eng_valid <= 1'b1;
            r_state     <= ISSUE;
            if (!if_req)
              r_starve <= '0;
            else if (!w_starve_full)
              r_starve <= r_starve + 4'd1;
          end else if (if_req) begin
            r_own_if    <= 1'b1;
            r_eng_wr    <= 1'b0;
            r_eng_addr  <= if_addr;
            r_eng_len   <= 3'd4;
            r_eng_wdata <= '0;
            r_eng_valid <= 1'b1;
            r_starve    <= '0;
            r_discard   <= flush;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush && r_own_if)
            r_discard <= 1'b1;
          if (eng_ready) begin
            r_eng_valid <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (flush && r_own_if)
            r_discard <= 1'b1;
          if (eng_done) begin
            if (r_own_if) begin
              if (!w_kill) begin
                r_if_inst <= eng_rdata;
                r_if_done <= 1'b1;
              end
            end else begin
              r_ls_rdata <= w_rdata_ext;
              r_ls_done  <= 1'b1;
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          r_if_done <= 1'b0;
          r_ls_done <= 1'b0;
          r_discard <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_done   = r_if_done;
  assign if_inst   = r_if_inst;
  assign ls_done   = r_ls_done;
  assign ls_rdata  = r_ls_rdata;
  assign eng_valid = r_eng_valid;
  assign eng_wr    = r_eng_wr;
  assign eng_addr  = r_eng_addr;
  assign eng_len   = r_eng_len;
  assign eng_wdata = r_eng_wdata;

endmodule
